// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared state type, default sizes and index-width helper for the FIFO write arbiter
package fifo_wr_arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_REQ = 4;
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request after last in ascending wrap-around order
module rr_pick import fifo_wr_arb_pkg::*; #(
  parameter int N = DEF_NUM_REQ,
  parameter int W = grant_w(DEF_NUM_REQ)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] k;
  always_comb begin
    found = |req;
    idx = '0;
    k = '0;
    // scan farthest-first so the nearest candidate after last wins
    for (int i = N; i >= 1; i--) begin
      k = W'((int'(last) + i) % N);
      if (req[k]) idx = k;
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ bursty producers.
// Define FIFO_WR_ARB_TIMEOUT_EN to release a grant after TIMEOUT_CYC idle cycles.
module fifo_wr_arbiter import fifo_wr_arb_pkg::*; #(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BURST_MAX   = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_din,
  input  logic                       fifo_full,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int GW = grant_w(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  state_e state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [BW-1:0] beat_q, beat_d;
  logic found, g_valid, acc, rel, tmo_rel;
  logic [DATA_W-1:0] g_data;
  rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req(req_valid),
    .last(last_q),
    .found(found),
    .idx(pick)
  );
  always_comb begin
    busy = state_q == GRANT;
    grant_id = grant_q;
    g_valid = req_valid[grant_q];
    g_data = req_data[int'(grant_q)*DATA_W +: DATA_W];
    acc = busy && g_valid && !fifo_full;
    rel = acc && (req_last[grant_q] || beat_q == BW'(BURST_MAX - 1));
    fifo_wr_en = acc;
    fifo_din = busy ? g_data : '0;
    req_ready = (busy && !fifo_full) ? NUM_REQ'(1) << grant_q : '0;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    beat_d = beat_q;
    if (!busy) begin
      if (found) begin
        state_d = GRANT;
        grant_d = pick;
        beat_d = '0;
      end
    end else if (rel || tmo_rel) begin
      state_d = IDLE;
      last_d = grant_q;
      beat_d = '0;
    end else if (acc) begin
      beat_d = beat_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NUM_REQ - 1);
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      beat_q <= beat_d;
    end
  end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic idle_cyc;
  // full cycles pause the count; an accepted beat or a new grant restarts it
  always_comb begin
    idle_cyc = busy && !g_valid && !fifo_full;
    tmo_rel = idle_cyc && tmo_q == TW'(TIMEOUT_CYC - 1);
    tmo_d = (!busy || acc || tmo_rel) ? '0 : idle_cyc ? tmo_q + 1'b1 : tmo_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  always_comb tmo_rel = 1'b0 && (TIMEOUT_CYC > 0);
`endif
endmodule
